cfu_popcount_initiator: RTL

- CPU-side requester (initiator) for a Level-1 (handshaked) popcount CFU: streams a command-specified number of 32b words into the CFU request channel, collects in-order responses, and accumulates a total population count.
- Sits between a word source (DMA/load stream) and any Popcount32-function CFU; returns one summed result per command.
- Supports up to MAX_OUT requests in flight, so a pipelined CFU is fed back-to-back.

---
 rtl/cfu_popcount_initiator.sv | 109 ++++++++++
 1 files changed

// File: rtl/cfu_popcount_initiator.sv
// cfu_popcount_initiator: streams cmd_len words into a handshaked popcount CFU, keeps up to MAX_OUT requests in flight and sums the in-order responses; define CFU_POPCOUNT_INIT_SAT_EN for a saturating accumulator with a sticky done_sat flag.
module cfu_popcount_initiator #(
    parameter int FUNC_ID_W = 10,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int ACC_W     = 32,
    parameter int MAX_OUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [FUNC_ID_W-1:0] cmd_function_id,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic [DATA_W-1:0]    word_data,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [FUNC_ID_W-1:0] req_function_id,
    output logic [DATA_W-1:0]    req_data,
    input  logic                 resp_valid,
    output logic                 resp_ready,
    input  logic [DATA_W-1:0]    resp_data,
    output logic                 done_valid,
    input  logic                 done_ready,
`ifdef CFU_POPCOUNT_INIT_SAT_EN
    output logic                 done_sat,
`endif
    output logic [ACC_W-1:0]     done_sum
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]           state_q, state_d;
    logic [LEN_W-1:0]     len_q, issued_q, received_q;
    logic [FUNC_ID_W-1:0] fid_q;
    logic [3:0]           out_q;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 resp_fire, last_resp;
`ifdef CFU_POPCOUNT_INIT_SAT_EN
    logic                 sat_q, sat_d;
    logic [ACC_W:0]       sum;
    assign done_sat = sat_q;
`endif
    assign cmd_ready       = state_q == IDLE;
    assign req_valid       = (state_q == RUN) && word_valid && (issued_q < len_q) && (out_q < 4'(MAX_OUT));
    assign word_ready      = req_valid && req_ready;
    assign req_data        = word_data;
    assign req_function_id = fid_q;
    assign resp_ready      = state_q == RUN;
    assign resp_fire       = resp_valid && resp_ready;
    assign last_resp       = resp_fire && (received_q + 1'b1 == len_q);
    assign done_valid      = state_q == DONE;
    assign done_sum        = acc_q;
    // accumulator update for one response, wrapping or saturating
    always_comb begin
`ifdef CFU_POPCOUNT_INIT_SAT_EN
        sum   = {1'b0, acc_q} + {1'b0, ACC_W'(resp_data)};
        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        sat_d = sat_q | sum[ACC_W];
`else
        acc_d = acc_q + ACC_W'(resp_data);
`endif
    end
    // IDLE -> RUN (or straight to DONE for an empty command) -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && cmd_valid) state_d = (cmd_len == '0) ? DONE : RUN;
        else if (state_q == RUN && last_resp) state_d = DONE;
        else if (state_q == DONE && done_ready) state_d = IDLE;
    end
    // command latch, issue/receive/in-flight counters and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            fid_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            out_q      <= '0;
            acc_q      <= '0;
`ifdef CFU_POPCOUNT_INIT_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (cmd_ready && cmd_valid) begin
                len_q      <= cmd_len;
                fid_q      <= cmd_function_id;
                issued_q   <= '0;
                received_q <= '0;
                out_q      <= '0;
                acc_q      <= '0;
`ifdef CFU_POPCOUNT_INIT_SAT_EN
                sat_q      <= 1'b0;
`endif
            end else begin
                if (word_ready) issued_q <= issued_q + 1'b1;
                if (resp_fire) begin
                    received_q <= received_q + 1'b1;
                    acc_q      <= acc_d;
`ifdef CFU_POPCOUNT_INIT_SAT_EN
                    sat_q      <= sat_d;
`endif
                end
                out_q <= out_q + 4'(word_ready) - 4'(resp_fire);
            end
        end
    end
endmodule
